// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The fetch FSM state encoding, the canonical NOP, and small address/opcode helpers live here.
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0: what the output register shows before any fetch completes
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Major opcode of the B-type conditional branches consumed downstream
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } fetch_state_t;

    // Word-aligned version of an address (instruction memory ignores the low bits)
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // True when an address is not on a 4-byte boundary
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    // True when an instruction word is a conditional branch
    function automatic logic is_branch(input logic [XLEN-1:0] instr);
        return instr[6:0] == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction-memory req/ack port, downstream
// valid/ready port and the redirect input from the branch stage.
// master = fetch unit side, slave = memory / downstream / branch stage side.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/ack memory port and presents {pc, instruction} downstream.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- misaligned redirect
// targets (or a misaligned RESET_PC) park the unit in a sticky error state
// and expose misalign_err; without it the low PC bits are ignored on fetch.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic               misalign_err
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;

    logic [XLEN-1:0] pc_seq;
    logic            bad_start;
    logic            bad_redirect;

    // Sequential successor of the current PC; wraps modulo 2^32
    assign pc_seq = pc_q + PC_STEP[XLEN-1:0];

`ifdef FETCH_MISALIGN_CHECK_EN
    assign bad_start    = is_misaligned(pc_q);
    assign bad_redirect = bus.redirect_valid && is_misaligned(bus.redirect_pc);
    assign misalign_err = (state_q == ERR);
`else
    assign bad_start    = 1'b0;
    assign bad_redirect = 1'b0;
`endif

    assign bus.imem_req  = (state_q == REQ);
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_pc    = out_pc_q;
    assign bus.out_instr = out_instr_q;

    // Next-state logic: request issue, ack capture, kill of stale fetches and redirects.
    // addr_q is only reloaded when a new request starts, so the address of an
    // in-flight request stays put even after a redirect has moved the PC.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        kill_d      = kill_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;

        unique case (state_q)
            IDLE: begin
                if (bad_start) begin
                    state_d = ERR;
                end else begin
                    state_d = REQ;
                    addr_d  = align_word(pc_q);
                    kill_d  = 1'b0;
                end
            end

            REQ: begin
                if (bad_redirect) begin
                    state_d = ERR;
                    kill_d  = 1'b0;
                end else begin
                    if (bus.redirect_valid) begin
                        pc_d = bus.redirect_pc;
                    end
                    if (bus.imem_ack) begin
                        if (kill_q || bus.redirect_valid) begin
                            addr_d = align_word(pc_d);
                            kill_d = 1'b0;
                        end else begin
                            out_pc_d    = pc_q;
                            out_instr_d = bus.imem_rdata;
                            state_d     = HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        kill_d = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (bad_redirect) begin
                    state_d = ERR;
                end else if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    addr_d  = align_word(bus.redirect_pc);
                    state_d = REQ;
                end else if (bus.out_ready) begin
                    pc_d    = pc_seq;
                    addr_d  = align_word(pc_seq);
                    state_d = REQ;
                end
            end

            ERR: begin
                state_d = ERR;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= '0;
            kill_q      <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            kill_q      <= kill_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

endmodule
